// File: rtl/kgp_flags_pkg.sv
// Shared flag definitions for the branch-condition path: flag vector layout,
// scoreboard limits and the opcode classes that decide whether carry is written.
package kgp_flags_pkg;

    typedef struct packed {
        logic zero;
        logic sign;
        logic carry;
    } flags_t;

    localparam int FLAG_Z = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_C = 0;

    localparam int MAX_PENDING_LIMIT = 7;

    typedef enum logic [1:0] {
        OPC_LOGIC = 2'd0,
        OPC_ADD   = 2'd1,
        OPC_COMP  = 2'd2,
        OPC_SHIFT = 2'd3
    } opc_class_t;

    // Only arithmetic and compare classes produce a meaningful carry.
    function automatic logic opc_updates_carry(opc_class_t opc);
        return (opc == OPC_ADD) || (opc == OPC_COMP);
    endfunction

endpackage

// File: rtl/flag_scoreboard_calc.sv
// Combinational next-flag computation from an ALU result; carry is held
// unless the result belongs to a carry-producing instruction class.
module flag_calc
    import kgp_flags_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] res_data,
    input  logic             res_carry,
    input  logic             res_upd_c,
    input  flags_t           cur,
    output flags_t           nxt
);

    always_comb begin
        nxt       = cur;
        nxt.zero  = (res_data == '0);
        nxt.sign  = res_data[WIDTH-1];
        nxt.carry = res_upd_c ? res_carry : cur.carry;
    end

endmodule

// File: rtl/flag_scoreboard.sv
// Flag register with an outstanding-instruction scoreboard: tracks issued
// flag-setting instructions and qualifies the flags for jump control.
module flag_scoreboard
    import kgp_flags_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MAX_PENDING = 3,
    parameter int BYPASS      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_valid,
    output logic             iss_ready,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] res_data,
    input  logic             res_carry,
    input  logic             res_upd_c,
    input  logic             flush,
    output logic             flag_zero,
    output logic             flag_sign,
    output logic             flag_carry,
    output logic             flags_valid,
    output logic [2:0]       pending_cnt,
    output logic             err_spurious
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_PENDING);

    logic [2:0] count;
    logic [2:0] count_nxt;
    logic       commit;
    logic       accept;
    logic       spurious;
    flags_t     flags_q;
    flags_t     flags_calc;
    flags_t     flags_out;

    assign commit    = res_valid && !flush && (count != 3'd0);
    assign spurious  = res_valid && !flush && (count == 3'd0);
    assign iss_ready = (count < MAX_CNT) || commit;
    assign accept    = iss_valid && iss_ready;

    // A flush drops every older instruction but keeps a same-cycle issue.
    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = accept ? 3'd1 : 3'd0;
        end else if (accept && !commit) begin
            count_nxt = count + 3'd1;
        end else if (commit && !accept) begin
            count_nxt = count - 3'd1;
        end
    end

    flag_calc #(
        .WIDTH(WIDTH)
    ) u_calc (
        .res_data (res_data),
        .res_carry(res_carry),
        .res_upd_c(res_upd_c),
        .cur      (flags_q),
        .nxt      (flags_calc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count        <= 3'd0;
            flags_q      <= '0;
            err_spurious <= 1'b0;
        end else begin
            count <= count_nxt;
            if (commit) begin
                flags_q <= flags_calc;
            end
            if (spurious) begin
                err_spurious <= 1'b1;
            end
        end
    end

    // Bypass lets a branch waiting on the last outstanding result resolve in the commit cycle.
    generate
        if (BYPASS != 0) begin : g_bypass
            assign flags_out   = commit ? flags_calc : flags_q;
            assign flags_valid = (count == 3'd0) || ((count == 3'd1) && commit && !accept);
        end else begin : g_registered
            assign flags_out   = flags_q;
            assign flags_valid = (count == 3'd0);
        end
    endgenerate

    assign flag_zero   = flags_out[FLAG_Z];
    assign flag_sign   = flags_out[FLAG_S];
    assign flag_carry  = flags_out[FLAG_C];
    assign pending_cnt = count;

endmodule

// File: tb/tb_flag_scoreboard.sv
// Directed bench for flag_scoreboard: a bypassed and a registered instance
// share one stimulus stream; expected values are hand-computed per step.
module tb_flag_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_carry;
    logic        res_upd_c;
    logic        flush;

    logic        iss_ready, flag_zero, flag_sign, flag_carry, flags_valid, err_spurious;
    logic [2:0]  pending_cnt;
    logic        nb_iss_ready, nb_zero, nb_sign, nb_carry, nb_valid, nb_err;
    logic [2:0]  nb_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flag_scoreboard #(.WIDTH(32), .MAX_PENDING(3), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid), .iss_ready(iss_ready),
        .res_valid(res_valid), .res_data(res_data), .res_carry(res_carry),
        .res_upd_c(res_upd_c), .flush(flush), .flag_zero(flag_zero),
        .flag_sign(flag_sign), .flag_carry(flag_carry), .flags_valid(flags_valid),
        .pending_cnt(pending_cnt), .err_spurious(err_spurious)
    );

    flag_scoreboard #(.WIDTH(32), .MAX_PENDING(3), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid), .iss_ready(nb_iss_ready),
        .res_valid(res_valid), .res_data(res_data), .res_carry(res_carry),
        .res_upd_c(res_upd_c), .flush(flush), .flag_zero(nb_zero),
        .flag_sign(nb_sign), .flag_carry(nb_carry), .flags_valid(nb_valid),
        .pending_cnt(nb_cnt), .err_spurious(nb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        iss_valid = 1'b0;
        res_valid = 1'b0;
        res_data  = 32'h0;
        res_carry = 1'b0;
        res_upd_c = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic result(input logic [31:0] d, input logic c, input logic u);
        res_valid = 1'b1;
        res_data  = d;
        res_carry = c;
        res_upd_c = u;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #12;
        chk("rst_cnt", 32'(pending_cnt), 32'd0);
        chk("rst_flags", {flag_zero, flag_sign, flag_carry}, 32'd0);
        chk("rst_err", 32'(err_spurious), 32'd0);
        chk("rst_valid", 32'(flags_valid), 32'd1);
        chk("rst_ready", 32'(iss_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // single issue, then a zero result with carry written
        iss_valid = 1'b1;
        #3 chk("iss_cycle_valid", 32'(flags_valid), 32'd1);
        tick();
        iss_valid = 1'b0;
        #3 chk("after_iss_valid", 32'(flags_valid), 32'd0);
        chk("after_iss_cnt", 32'(pending_cnt), 32'd1);
        tick();
        result(32'h0, 1'b1, 1'b1);
        #3 chk("bypass_flags", {flag_zero, flag_sign, flag_carry}, 32'b101);
        chk("bypass_valid", 32'(flags_valid), 32'd1);
        chk("nb_commit_valid", 32'(nb_valid), 32'd0);
        chk("nb_commit_zero", 32'(nb_zero), 32'd0);
        tick();
        idle();
        #3 chk("nb_valid_rise", 32'(nb_valid), 32'd1);
        chk("nb_flags", {nb_zero, nb_sign, nb_carry}, 32'b101);
        chk("reg_flags", {flag_zero, flag_sign, flag_carry}, 32'b101);
        chk("cnt_drained", 32'(pending_cnt), 32'd0);

        // fill to MAX_PENDING, then overflow attempt
        iss_valid = 1'b1;
        tick();
        tick();
        #3 chk("cnt2_ready", 32'(iss_ready), 32'd1);
        tick();
        #3 chk("full_cnt", 32'(pending_cnt), 32'd3);
        chk("full_ready", 32'(iss_ready), 32'd0);
        chk("full_valid", 32'(flags_valid), 32'd0);
        tick();
        #3 chk("ignored_iss_cnt", 32'(pending_cnt), 32'd3);

        // issue + result at full count; sign result, carry held
        result(32'h8000_0000, 1'b0, 1'b0);
        #3 chk("full_commit_ready", 32'(iss_ready), 32'd1);
        chk("sign_bypass", {flag_zero, flag_sign, flag_carry}, 32'b011);
        chk("full_commit_valid", 32'(flags_valid), 32'd0);
        tick();
        iss_valid = 1'b0;
        #3 chk("full_swap_cnt", 32'(pending_cnt), 32'd3);
        chk("sign_reg", {flag_zero, flag_sign, flag_carry}, 32'b011);

        result(32'h0000_0005, 1'b0, 1'b0);
        tick();
        idle();
        #3 chk("cnt_two", 32'(pending_cnt), 32'd2);
        chk("flags_before_flush", {flag_zero, flag_sign, flag_carry}, 32'b001);

        // flush with a concurrent result that must be dropped
        flush = 1'b1;
        result(32'h0, 1'b0, 1'b1);
        #3 chk("flush_cycle_flags", {flag_zero, flag_sign, flag_carry}, 32'b001);
        tick();
        idle();
        #3 chk("flush_cnt", 32'(pending_cnt), 32'd0);
        chk("flush_flags", {flag_zero, flag_sign, flag_carry}, 32'b001);
        chk("flush_valid", 32'(flags_valid), 32'd1);
        chk("flush_no_err", 32'(err_spurious), 32'd0);

        // spurious result at count 0
        result(32'h0, 1'b0, 1'b1);
        #3 chk("spur_cycle_flags", {flag_zero, flag_sign, flag_carry}, 32'b001);
        tick();
        idle();
        #3 chk("spur_err", 32'(err_spurious), 32'd1);
        chk("spur_flags", {flag_zero, flag_sign, flag_carry}, 32'b001);
        chk("spur_cnt", 32'(pending_cnt), 32'd0);
        tick();
        #3 chk("spur_sticky", 32'(err_spurious), 32'd1);

        // flush with a concurrent accepted issue keeps one outstanding
        iss_valid = 1'b1;
        flush     = 1'b1;
        tick();
        idle();
        #3 chk("flush_iss_cnt", 32'(pending_cnt), 32'd1);
        chk("flush_iss_valid", 32'(flags_valid), 32'd0);

        // asynchronous reset in mid-cycle
        rst_n = 1'b0;
        #1 chk("arst_cnt", 32'(pending_cnt), 32'd0);
        chk("arst_flags", {flag_zero, flag_sign, flag_carry}, 32'd0);
        chk("arst_err", 32'(err_spurious), 32'd0);
        chk("arst_valid", 32'(flags_valid), 32'd1);
        chk("arst_ready", 32'(iss_ready), 32'd1);
        chk("arst_nb_err", 32'(nb_err), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
